// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples SCLK/WS/SD on clk and deserialises left+right words into one frame.
// Optional `define I2S_RX_FRAME_CNT_EN adds a frame_cnt output counting frames loaded into rx_data.
module i2s_receiver #(
    parameter int DWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  WS,
    input  logic                  SD,
    output logic [2*DWIDTH-1:0]   rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    output logic                  ws_err
`ifdef I2S_RX_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt
`endif
);

    localparam int FW = 2 * DWIDTH;
    localparam int CW = $clog2(FW);
    localparam logic [CW-1:0] HALF = CW'(DWIDTH);
    localparam logic [CW-1:0] LAST = CW'(FW - 1);

    typedef enum logic {ALIGN, RECV} state_t;

    state_t          state_q, state_d;
    logic            sclk_s1_q, sclk_s2_q, sclk_dly_q;
    logic            ws_s1_q, ws_s2_q;
    logic            sd_s1_q, sd_s2_q;
    logic            prev_ws_q, prev_ws_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FW-2:0]   shift_q, shift_d;
    logic [FW-1:0]   rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            overrun_q, overrun_d;
    logic            ws_err_q, ws_err_d;
    logic            bit_evt, ws_exp, frame_done;
    logic [FW-1:0]   frame_word;
`ifdef I2S_RX_FRAME_CNT_EN
    logic [15:0]     frame_cnt_q, frame_cnt_d;
`endif

    assign bit_evt    = sclk_s2_q & ~sclk_dly_q;
    assign ws_exp     = (bit_cnt_q >= HALF);
    // The last bit never enters the shift register; it is appended on completion.
    assign frame_word = {shift_q, sd_s2_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALIGN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bit_evt) begin
            case (state_q)
                ALIGN: if (!ws_s2_q && prev_ws_q) state_d = RECV;
                RECV: begin
                    if (ws_s2_q != ws_exp)       state_d = ALIGN;
                    else if (bit_cnt_q == LAST)  state_d = ALIGN;
                end
                default: state_d = ALIGN;
            endcase
        end
    end

    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        ws_err_d   = 1'b0;
        frame_done = 1'b0;
        prev_ws_d  = bit_evt ? ws_s2_q : prev_ws_q;
        if (bit_evt) begin
            case (state_q)
                ALIGN: begin
                    if (!ws_s2_q && prev_ws_q) begin
                        shift_d   = {{(FW-2){1'b0}}, sd_s2_q};
                        bit_cnt_d = CW'(1);
                    end
                end
                RECV: begin
                    if (ws_s2_q != ws_exp) begin
                        ws_err_d  = 1'b1;
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q == LAST) begin
                        frame_done = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        shift_d   = {shift_q[FW-3:0], sd_s2_q};
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
                default: bit_cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
`ifdef I2S_RX_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q;
`endif
        if (frame_done && (!rx_valid_q || rx_ready)) begin
            rx_data_d  = frame_word;
            rx_valid_d = 1'b1;
`ifdef I2S_RX_FRAME_CNT_EN
            frame_cnt_d = frame_cnt_q + 16'd1;
`endif
        end else if (frame_done) begin
            overrun_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_dly_q <= 1'b0;
            ws_s1_q    <= 1'b0;
            ws_s2_q    <= 1'b0;
            sd_s1_q    <= 1'b0;
            sd_s2_q    <= 1'b0;
            prev_ws_q  <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ws_err_q   <= 1'b0;
`ifdef I2S_RX_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            sclk_s1_q  <= SCLK;
            sclk_s2_q  <= sclk_s1_q;
            sclk_dly_q <= sclk_s2_q;
            ws_s1_q    <= WS;
            ws_s2_q    <= ws_s1_q;
            sd_s1_q    <= SD;
            sd_s2_q    <= sd_s1_q;
            prev_ws_q  <= prev_ws_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            ws_err_q   <= ws_err_d;
`ifdef I2S_RX_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign ws_err   = ws_err_q;
`ifdef I2S_RX_FRAME_CNT_EN
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: frame table plus hand-written corner sequences, queue scoreboard.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        SCLK, WS, SD;
    logic [15:0] rx_data;
    logic        rx_valid, rx_ready, overrun, ws_err;
`ifdef I2S_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int ws_err_cnt = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0]  left;
        logic [7:0]  right;
        logic [15:0] expect_word;
        bit          gap_before;
        bit          chk_lat;
    } vec_t;

    i2s_receiver #(.DWIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .SCLK     (SCLK),
        .WS       (WS),
        .SD       (SD),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overrun  (overrun),
        .ws_err   (ws_err)
`ifdef I2S_RX_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: every accepted frame is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (ws_err) ws_err_cnt++;
            if (rx_valid && rx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got %04h expected none", rx_data);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL frame_data: got %04h expected %04h", rx_data, e);
                    end
                end
            end
        end
    end

    // Called at a negedge; SCLK low 4 clk, high 4 clk.
    task automatic send_bit(input logic ws_v, input logic sd_v, input bit lat);
        SCLK = 1'b0; WS = ws_v; SD = sd_v;
        repeat (4) @(negedge clk);
        SCLK = 1'b1;
        if (lat) begin
            repeat (2) @(negedge clk);
            chk("latency_before", {31'd0, rx_valid}, 32'd0);
            @(negedge clk);
            chk("latency_at", {31'd0, rx_valid}, 32'd1);
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [15:0] word, input bit glitch, input bit lat, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            logic ws_v;
            ws_v = glitch ? (i >= 3) : (i >= 8);
            send_bit(ws_v, word[15-i], lat && (i == 15));
        end
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 16'hA53C, 1'b1, 1'b1};
        vecs[1] = '{8'h12, 8'h34, 16'h1234, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 16'hFFFF, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h01, 16'h0001, 1'b0, 1'b0};

        rst = 1'b1; SCLK = 1'b0; WS = 1'b1; SD = 1'b0; rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_rx_data", {16'd0, rx_data}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        chk("reset_ws_err", {31'd0, ws_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].gap_before) repeat (20) @(negedge clk);
            exp_q.push_back(vecs[v].expect_word);
            send_frame({vecs[v].left, vecs[v].right}, 1'b0, vecs[v].chk_lat, 16);
        end
        repeat (20) @(negedge clk);
        chk("table_overrun", {31'd0, overrun}, 32'd0);
        chk("table_ws_err", ws_err_cnt, 32'd0);
        chk("table_drained", exp_q.size(), 32'd0);

        // WS glitch on bit 3 of the left word, then a clean frame.
        send_frame(16'hA0A0, 1'b1, 1'b0, 16);
        exp_q.push_back(16'hBEEF);
        send_frame(16'hBEEF, 1'b0, 1'b0, 16);
        repeat (20) @(negedge clk);
        chk("glitch_ws_err_pulses", ws_err_cnt, 32'd1);
        chk("glitch_drained", exp_q.size(), 32'd0);

        // Backpressure: second frame must be dropped.
        rx_ready = 1'b0;
        exp_q.push_back(16'h1111);
        send_frame(16'h1111, 1'b0, 1'b0, 16);
        send_frame(16'h2222, 1'b0, 1'b0, 16);
        repeat (10) @(negedge clk);
        chk("bp_rx_valid", {31'd0, rx_valid}, 32'd1);
        chk("bp_rx_data", {16'd0, rx_data}, 32'h1111);
        chk("bp_overrun", {31'd0, overrun}, 32'd1);
`ifdef I2S_RX_FRAME_CNT_EN
        chk("frame_cnt_before_reset", {16'd0, frame_cnt}, 32'd6);
`endif
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_cleared", {31'd0, rx_valid}, 32'd0);
        chk("bp_drained", exp_q.size(), 32'd0);

        // Reset after 5 bits of a frame.
        send_frame(16'h5555, 1'b0, 1'b0, 5);
        rst = 1'b1; SCLK = 1'b0; WS = 1'b1;
        @(negedge clk);
        chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("midrst_rx_data", {16'd0, rx_data}, 32'd0);
        chk("midrst_overrun", {31'd0, overrun}, 32'd0);
        chk("midrst_ws_err", {31'd0, ws_err}, 32'd0);
`ifdef I2S_RX_FRAME_CNT_EN
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(16'h0F0F);
        send_frame(16'h0F0F, 1'b0, 1'b0, 16);
        repeat (20) @(negedge clk);
        chk("post_rst_drained", exp_q.size(), 32'd0);
        chk("post_rst_overrun", {31'd0, overrun}, 32'd0);
        chk("post_rst_ws_err", ws_err_cnt, 32'd1);
`ifdef I2S_RX_FRAME_CNT_EN
        chk("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Downstream stage of the I2S transmitter. Oversamples the external I2S bus (SCLK, WS, SD) with the system clock.
- Deserialises one stereo frame (left word, then right word, MSB first) into a 2*DWIDTH-bit word.
- Presents each frame on a valid/ready output with overrun and word-select error reporting. Feeds the sample sink (FIFO/DSP) of the audio path.

Parameters:
- DWIDTH, 8, bits per channel word; the frame is 2*DWIDTH bits.

Ports:
- clk, input, 1, system clock; must run at least 4x SCLK, with SCLK high and low phases each at least 2 clk periods.
- rst, input, 1, synchronous, active-high reset.
- SCLK, input, 1, I2S bit clock; asynchronous to clk.
- WS, input, 1, I2S word select; 0 = left word, 1 = right word.
- SD, input, 1, I2S serial data.
- rx_data, output, 2*DWIDTH, received frame: {left[DWIDTH-1:0], right[DWIDTH-1:0]}.
- rx_valid, output, 1, rx_data holds an unconsumed frame.
- rx_ready, input, 1, sink accepts rx_data when rx_valid && rx_ready.
- overrun, output, 1, sticky: a completed frame was dropped.
- ws_err, output, 1, one-cycle pulse on a WS alignment violation.

Behaviour:
- Clock and reset: single clock domain (clk). Reset is synchronous and active-high on rst; all state updates on posedge clk.
- Reset values: rx_data=0, rx_valid=0, overrun=0, ws_err=0, state=ALIGN, bit_cnt=0, prev_ws=1, all synchroniser flops=0.
- Input sampling:
  - SCLK, WS and SD each pass through a 2-flop synchroniser.
  - An SCLK rising edge ("bit event") is detected when synchronised SCLK=1 and its delayed copy=0.
  - On a bit event, the synchronised WS and SD are the sampled values.
- ALIGN state:
  - Bit event with ws=0 and prev_ws=1 → frame start: shift register gets SD as bit 0, bit_cnt=1, go to RECV.
  - Any other bit event is ignored.
  - prev_ws updates on every bit event in every state.
- RECV state, on each bit event:
  - Expected WS is 0 for bit_cnt < DWIDTH and 1 for DWIDTH ≤ bit_cnt < 2*DWIDTH.
  - Match → shift SD into the LSB, bit_cnt+1.
  - Mismatch → ws_err=1 for exactly one clk, discard the partial frame, bit_cnt=0, go to ALIGN. The mismatching event is not reused as a frame start.
  - When the 2*DWIDTH-th bit is shifted in → frame complete, bit_cnt=0, go to ALIGN.
- Frame complete:
  - If rx_valid=0, or rx_ready=1 in the same cycle: load rx_data, rx_valid=1.
  - Else: keep the old rx_data, drop the new frame, set overrun=1.
  - overrun clears only on rst.
- Latency: rx_valid rises on the 3rd clk edge counting the edge where SCLK of the last bit is first sampled high.
- Handshake:
  - rx_valid stays high until rx_valid && rx_ready.
  - rx_data is stable while rx_valid=1.
  - Simultaneous accept and new completion → rx_valid stays 1 with the new data; no overrun.
- Gaps: SCLK stopping between frames (e.g. during the transmitter LOAD cycle) is legal; state is held indefinitely.
- Back-to-back frames: WS dropping 1→0 directly after the right word starts the next frame with no lost bit.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values on the next clk edge.

Optional Feature:
- Macro: I2S_RX_FRAME_CNT_EN.
- Defined:
  - Extra output port frame_cnt [15:0], reset 0.
  - Increments by 1 on every frame loaded into rx_data, wrapping 0xFFFF→0.
  - Dropped (overrun) frames and ws_err-discarded frames do not count.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- All tests use DWIDTH=8, SCLK=clk/8, rx_ready=1.
- Single frame: send left=0xA5, right=0x3C → one rx_valid pulse, rx_data=0xA53C, overrun=0, ws_err=0.
- Back-to-back: send 0x1234 then 0xFFFF then 0x0001 with no gap → three accepted frames in order with exactly those values.
- Backpressure: rx_ready=0, send 0x1111 then 0x2222 → rx_data stays 0x1111, overrun=1. Raise rx_ready → 0x1111 accepted, then rx_valid=0.
- WS glitch: drive WS=1 during bit 3 of the left word, then send a clean frame 0xBEEF → one ws_err pulse; only 0xBEEF is delivered.
- Reset mid-frame: assert rst after 5 bits, release, send 0x0F0F → all outputs 0 during reset, then exactly one frame 0x0F0F.
- With I2S_RX_FRAME_CNT_EN: send 3 good frames plus 1 overrun-dropped frame → frame_cnt=3.
